ddr3_init_seq: RTL and testbench
================================

// Module: ddr3_init_seq
// PURPOSE
//  Parametrised DDR3 power-up/configuration sequencer; successor to ddr3_cfg. Drives RESET#/CKE/CS#/ODT
//  directly, issues MR2/MR3/MR1/MR0/ZQCL through the ctl request port, then raises ctl_run_o. After init it
//  tracks refresh debt with postponement (up to REF_POSTPONE pending REFs) and performs runtime mode-register
//  writes (PRE-all, MRS, tMOD) on request. Sits between ddr3_fsm's cfg port and the DFI/PHY control IOBs.
// PARAMETERS
//  DDR_FREQ_MHZ  100  controller `clock` frequency; all waits computed in `clock` cycles
//  DDR_ROW_BITS  13   row/address bus width (RSB = DDR_ROW_BITS-1)
//  CL            6    CAS latency, 5..11; encoded into MR0
//  CWL           5    CAS write latency, 5..8; encoded into MR2
//  WR            6    write recovery, 5..8,10,12; encoded into MR0
//  RTT_NOM       0    MR1 {A9,A6,A2} ODT encoding
//  REF_POSTPONE  8    max pending refreshes before ctl_urg_o, 1..8
//  TIME_DIV      1    divides 200us/500us power-up waits (simulation only; 1 for silicon)
// PORTS
//  clock          in   1    controller clock
//  reset_n        in   1    asynchronous, active-low reset
//  dfi_rst_no     out  1    DDR3 RESET#
//  dfi_cke_o      out  1    CKE
//  dfi_cs_no      out  1    CS#
//  dfi_odt_o      out  1    ODT (held 0 by this block)
//  ctl_req_o      out  1    command request to DDL path
//  ctl_rdy_i      in   1    command accepted this cycle
//  ctl_cmd_o      out  3    {RAS#,CAS#,WE#} command (CMD_* constants)
//  ctl_ba_o       out  3    bank address
//  ctl_adr_o      out  RSB+1 address
//  ctl_run_o      out  1    memory controller owns command path
//  ctl_idle_i     in   1    controller quiescent, no open rows/in-flight bursts
//  ctl_ref_o      out  1    refresh pending (debt > 0)
//  ctl_urg_o      out  1    debt >= REF_POSTPONE; controller must refresh next
//  ctl_ref_ack_i  in   1    1-cycle pulse: controller issued one REF
//  ref_ovf_o      out  1    sticky: tick arrived with debt already 8
//  mrs_req_i      in   1    runtime MRS request (level, held until ack)
//  mrs_ba_i       in   3    MRS target register
//  mrs_adr_i      in   RSB+1 MRS value
//  mrs_ack_o      out  1    1-cycle pulse: MRS sequence complete
// BEHAVIOUR
//  Reset values: dfi_rst_no=0, cke=0, cs_no=1, odt=0, req=0, cmd=CMD_NOOP, ba=0, adr=0, run/ref/urg/ovf/ack=0.
//  reset_n low at any time: outputs to reset values immediately, FSM to ST_RST, debt=0; full init re-runs.
//  States: ST_RST (T_RST=200us/TIME_DIV) -> ST_CKEL (rst_no=1, T_CKE=500us/TIME_DIV) -> ST_XPR (cke=1,
//   cs_no=0, tXPR) -> ST_MR2 -> ST_MR3 -> ST_MR1 -> ST_MR0 -> ST_ZQCL -> ST_RUN <-> ST_MPRE/ST_MMRS/ST_MWAIT.
//  Command handshake: req/cmd/ba/adr registered, held stable until ctl_rdy_i high in a cycle with req=1; req
//   falls next cycle, cmd->NOOP, wait counter loads (tMRD after MR2/3/1, tMOD after MR0, tZQinit+tDLLK after ZQCL).
//  MR values: MR2 ba=2 A5:3=CWL-5; MR3 ba=3 adr=0; MR1 ba=1 DLL on, RZQ/6, RTT_NOM; MR0 ba=0 BL8, A6:4/A2 from CL,
//   A8=1 (DLL reset), A11:9 from WR; ZQCL adr[10]=1.
//  ctl_run_o rises on the cycle after the ZQCL wait expires.
//  Refresh: tREFI timer (7.8us) runs only in ST_RUN and runtime-MRS states; debt 0..8 counter. tick&ack same
//   cycle: unchanged; ack with debt 0: ignored; tick at 8: saturate, set ref_ovf_o. ref=|debt, urg=debt>=REF_POSTPONE.
//  Runtime MRS: in ST_RUN with mrs_req_i: drop ctl_run_o; wait ctl_idle_i; PRE-all (adr[10]=1) then tRP;
//   MRS with captured ba/adr; tMOD; mrs_ack_o pulse, ctl_run_o rises same cycle. New request not sampled until
//   the cycle after ack. If ctl_urg_o is high in ST_RUN, mrs_req_i is deferred until urg clears.
// STRUCTURE
//  Package ddr3_settings.vh: CMD_* codes, tXPR/tMRD/tMOD/tRP/tREFI/tZQinit/tDLLK cycle counts from DDR_FREQ_MHZ,
//   MR0/MR1/MR2 encode functions, ST_* state encodings.
//  Sub-module ddr3_refresh_ctr: tREFI timer + saturating debt counter, ref/urg/ovf outputs.
// TESTING (DDR_FREQ_MHZ=100, TIME_DIV=100, CL=6, CWL=5, WR=6, ctl_rdy_i=1 unless stated)
//  Release reset_n -> rst_no rises after 200 cycles, cke after +500; MR2 adr=0x000, MR3 0x000, MR0 adr=0x520, ZQCL adr=0x400, run=1.
//  ctl_rdy_i low 10 cycles during MR1 -> req/cmd/ba/adr stable all 10 cycles; MR0 not issued before accept.
//  No acks in run -> ref at 780 cycles, urg after 8 ticks, 9th tick sets ref_ovf_o, debt stays 8; tick+ack same cycle -> debt unchanged.
//  mrs_req_i ba=1 adr=0x044, ctl_idle_i delayed 5 cycles -> run=0, PRE held off 5 cycles, PRE adr[10]=1, MRS ba=1 adr=0x044, ack 1 cycle, run=1.
//  reset_n low during MR3 wait -> all outputs at reset values same cycle; full sequence repeats from ST_RST.
//  ctl_ref_ack_i pulse with debt 0 -> debt stays 0, ref_ovf_o stays 0.

Source files
------------

// File: rtl/ddr3_init_seq_pkg.sv
// DDR3 init sequencer shared definitions: command codes, FSM states,
// clock-cycle timing helpers and mode-register encoders.
package ddr3_init_seq_pkg;

  localparam logic [2:0] CMD_MRS  = 3'b000;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_ZQCL = 3'b110;
  localparam logic [2:0] CMD_NOOP = 3'b111;

  localparam int unsigned T_MRD     = 4;
  localparam int unsigned T_ZQ_DLLK = 1024;  // tZQinit (512 nCK) + tDLLK (512 nCK)
  localparam logic [3:0]  REF_DEBT_MAX = 4'd8;

  typedef enum logic [3:0] {
    ST_RST, ST_CKEL, ST_XPR, ST_MR2, ST_MR3, ST_MR1, ST_MR0, ST_ZQCL,
    ST_RUN, ST_MIDLE, ST_MPRE, ST_MMRS, ST_MWAIT
  } state_e;

  function automatic int unsigned ns2clk(input int unsigned freq_mhz, input int unsigned ns);
    return (ns * freq_mhz + 999) / 1000;
  endfunction

  function automatic int unsigned us2clk(input int unsigned freq_mhz, input int unsigned us,
                                         input int unsigned div);
    return (us * freq_mhz) / div;
  endfunction

  function automatic int unsigned clk_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // MR0: BL8 fixed, CL on A6:4 (A2=0 for CL 5..11), DLL reset, WR on A11:9
  function automatic logic [15:0] mr0_enc(input int unsigned cl, input int unsigned wr);
    logic [15:0] v;
    logic [2:0]  wr_code;
    case (wr)
      5:       wr_code = 3'd1;
      6:       wr_code = 3'd2;
      7:       wr_code = 3'd3;
      8:       wr_code = 3'd4;
      10:      wr_code = 3'd5;
      12:      wr_code = 3'd6;
      default: wr_code = 3'd0;
    endcase
    v       = '0;
    v[6:4]  = 3'(cl - 4);
    v[8]    = 1'b1;
    v[11:9] = wr_code;
    return v;
  endfunction

  // MR1: DLL enabled, RZQ/6 drive (A5,A1 = 0), RTT_NOM on {A9,A6,A2}
  function automatic logic [15:0] mr1_enc(input logic [2:0] rtt);
    logic [15:0] v;
    v    = '0;
    v[9] = rtt[2];
    v[6] = rtt[1];
    v[2] = rtt[0];
    return v;
  endfunction

  function automatic logic [15:0] mr2_enc(input int unsigned cwl);
    logic [15:0] v;
    v      = '0;
    v[5:3] = 3'(cwl - 5);
    return v;
  endfunction

endpackage

// File: rtl/ddr3_init_seq_refresh_ctr.sv
// tREFI interval timer plus saturating refresh-debt counter (0..8) with
// pending/urgent/overflow flags.
module ddr3_init_seq_refresh_ctr
  import ddr3_init_seq_pkg::*;
#(
  parameter int unsigned T_REFI       = 780,
  parameter int unsigned REF_POSTPONE = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en_i,
  input  logic ack_i,
  output logic ref_o,
  output logic urg_o,
  output logic ovf_o
);

  localparam int unsigned CNT_W = $clog2(T_REFI + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       debt_q, debt_d;
  logic             ref_q, urg_q, ovf_q, ovf_d;
  logic             tick_c;

  always_comb begin
    cnt_d  = cnt_q;
    tick_c = 1'b0;
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (en_i) begin
      if (cnt_q == CNT_W'(T_REFI - 1)) begin
        cnt_d  = '0;
        tick_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Simultaneous tick and ack cancel out
    if (tick_c && !ack_i) begin
      if (debt_q == REF_DEBT_MAX) ovf_d = 1'b1;
      else                        debt_d = debt_q + 4'd1;
    end else if (ack_i && !tick_c && (debt_q != 4'd0)) begin
      debt_d = debt_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      debt_q <= '0;
      ref_q  <= 1'b0;
      urg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      debt_q <= debt_d;
      ref_q  <= |debt_d;
      urg_q  <= (debt_d >= 4'(REF_POSTPONE));
      ovf_q  <= ovf_d;
    end
  end

  assign ref_o = ref_q;
  assign urg_o = urg_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up/configuration sequencer: RESET#/CKE bring-up, MR2/MR3/MR1/MR0/ZQCL,
// then hands the command path to the controller; runtime MRS and refresh-debt tracking.
module ddr3_init_seq
  import ddr3_init_seq_pkg::*;
#(
  parameter int unsigned DDR_FREQ_MHZ = 100,
  parameter int unsigned DDR_ROW_BITS = 13,
  parameter int unsigned CL           = 6,
  parameter int unsigned CWL          = 5,
  parameter int unsigned WR           = 6,
  parameter int unsigned RTT_NOM      = 0,
  parameter int unsigned REF_POSTPONE = 8,
  parameter int unsigned TIME_DIV     = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic                    dfi_rst_no,
  output logic                    dfi_cke_o,
  output logic                    dfi_cs_no,
  output logic                    dfi_odt_o,
  output logic                    ctl_req_o,
  input  logic                    ctl_rdy_i,
  output logic [2:0]              ctl_cmd_o,
  output logic [2:0]              ctl_ba_o,
  output logic [DDR_ROW_BITS-1:0] ctl_adr_o,
  output logic                    ctl_run_o,
  input  logic                    ctl_idle_i,
  output logic                    ctl_ref_o,
  output logic                    ctl_urg_o,
  input  logic                    ctl_ref_ack_i,
  output logic                    ref_ovf_o,
  input  logic                    mrs_req_i,
  input  logic [2:0]              mrs_ba_i,
  input  logic [DDR_ROW_BITS-1:0] mrs_adr_i,
  output logic                    mrs_ack_o
);

  localparam int unsigned T_RST  = us2clk(DDR_FREQ_MHZ, 200, TIME_DIV);
  localparam int unsigned T_CKE  = us2clk(DDR_FREQ_MHZ, 500, TIME_DIV);
  localparam int unsigned T_XPR  = clk_max(5, ns2clk(DDR_FREQ_MHZ, 120));
  localparam int unsigned T_MOD  = clk_max(12, ns2clk(DDR_FREQ_MHZ, 15));
  localparam int unsigned T_RP   = ns2clk(DDR_FREQ_MHZ, 14);
  localparam int unsigned T_REFI = ns2clk(DDR_FREQ_MHZ, 7800);
  localparam int unsigned WAIT_W = $clog2(T_RST + T_CKE + T_ZQ_DLLK + 2);

  localparam logic [DDR_ROW_BITS-1:0] MR0_ADR = DDR_ROW_BITS'(mr0_enc(CL, WR));
  localparam logic [DDR_ROW_BITS-1:0] MR1_ADR = DDR_ROW_BITS'(mr1_enc(3'(RTT_NOM)));
  localparam logic [DDR_ROW_BITS-1:0] MR2_ADR = DDR_ROW_BITS'(mr2_enc(CWL));
  localparam logic [DDR_ROW_BITS-1:0] A10_ADR = DDR_ROW_BITS'(16'h0400);

  state_e                  state_q, state_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    sent_q, sent_d;
  logic [2:0]              mba_q, mba_d;
  logic [DDR_ROW_BITS-1:0] madr_q, madr_d;
  logic                    rst_n_q, rst_n_d, cke_q, cke_d, cs_n_q, cs_n_d;
  logic                    req_q, req_d, run_q, run_d, ack_q, ack_d;
  logic [2:0]              cmd_q, cmd_d, ba_q, ba_d;
  logic [DDR_ROW_BITS-1:0] adr_q, adr_d;
  logic                    accept_c, expired_c, ref_en_c;

  assign accept_c  = req_q & ctl_rdy_i;
  assign expired_c = (wait_q == '0);
  assign ref_en_c  = state_q inside {ST_RUN, ST_MIDLE, ST_MPRE, ST_MMRS, ST_MWAIT};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RST;
      wait_q  <= WAIT_W'(T_RST - 1);
      sent_q  <= 1'b0;
      mba_q   <= '0;
      madr_q  <= '0;
      rst_n_q <= 1'b0;
      cke_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      req_q   <= 1'b0;
      cmd_q   <= CMD_NOOP;
      ba_q    <= '0;
      adr_q   <= '0;
      run_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      sent_q  <= sent_d;
      mba_q   <= mba_d;
      madr_q  <= madr_d;
      rst_n_q <= rst_n_d;
      cke_q   <= cke_d;
      cs_n_q  <= cs_n_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      adr_q   <= adr_d;
      run_q   <= run_d;
      ack_q   <= ack_d;
    end
  end

  // Next state: command states request until accepted (sent), then count down their wait
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    sent_d  = sent_q;
    mba_d   = mba_q;
    madr_d  = madr_q;
    if (!expired_c) wait_d = wait_q - WAIT_W'(1);
    if (accept_c) begin
      sent_d = 1'b1;
      case (state_q)
        ST_MR0, ST_MMRS: wait_d = WAIT_W'(T_MOD - 1);
        ST_ZQCL:         wait_d = WAIT_W'(T_ZQ_DLLK - 1);
        ST_MPRE:         wait_d = WAIT_W'(T_RP - 1);
        default:         wait_d = WAIT_W'(T_MRD - 1);
      endcase
    end
    case (state_q)
      ST_RST:   if (expired_c) begin state_d = ST_CKEL; wait_d = WAIT_W'(T_CKE - 1); end
      ST_CKEL:  if (expired_c) begin state_d = ST_XPR;  wait_d = WAIT_W'(T_XPR - 1); end
      ST_XPR:   if (expired_c) state_d = ST_MR2;
      ST_MR2:   if (sent_q && expired_c) state_d = ST_MR3;
      ST_MR3:   if (sent_q && expired_c) state_d = ST_MR1;
      ST_MR1:   if (sent_q && expired_c) state_d = ST_MR0;
      ST_MR0:   if (sent_q && expired_c) state_d = ST_ZQCL;
      ST_ZQCL:  if (sent_q && expired_c) state_d = ST_RUN;
      ST_RUN: begin
        // Refresh urgency wins over MRS; ack cycle masks the still-held request
        if (mrs_req_i && !ctl_urg_o && !ack_q) begin
          state_d = ST_MIDLE;
          mba_d   = mrs_ba_i;
          madr_d  = mrs_adr_i;
        end
      end
      ST_MIDLE: if (ctl_idle_i) state_d = ST_MPRE;
      ST_MPRE:  if (sent_q && expired_c) state_d = ST_MMRS;
      ST_MMRS:  if (accept_c) state_d = ST_MWAIT;
      ST_MWAIT: if (expired_c) state_d = ST_RUN;
      default:  state_d = ST_RST;
    endcase
    if (state_d != state_q) sent_d = 1'b0;
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    rst_n_d = (state_d != ST_RST);
    cke_d   = !(state_d inside {ST_RST, ST_CKEL});
    cs_n_d  = !cke_d;
    run_d   = (state_d == ST_RUN);
    ack_d   = (state_q == ST_MWAIT) && (state_d == ST_RUN);
    req_d   = 1'b0;
    cmd_d   = CMD_NOOP;
    ba_d    = '0;
    adr_d   = '0;
    if (!sent_d) begin
      case (state_d)
        ST_MR2:  begin req_d = 1'b1; cmd_d = CMD_MRS;  ba_d = 3'd2;  adr_d = MR2_ADR; end
        ST_MR3:  begin req_d = 1'b1; cmd_d = CMD_MRS;  ba_d = 3'd3;  adr_d = '0;      end
        ST_MR1:  begin req_d = 1'b1; cmd_d = CMD_MRS;  ba_d = 3'd1;  adr_d = MR1_ADR; end
        ST_MR0:  begin req_d = 1'b1; cmd_d = CMD_MRS;  ba_d = 3'd0;  adr_d = MR0_ADR; end
        ST_ZQCL: begin req_d = 1'b1; cmd_d = CMD_ZQCL;               adr_d = A10_ADR; end
        ST_MPRE: begin req_d = 1'b1; cmd_d = CMD_PRE;                adr_d = A10_ADR; end
        ST_MMRS: begin req_d = 1'b1; cmd_d = CMD_MRS;  ba_d = mba_d; adr_d = madr_d;  end
        default: ;
      endcase
    end
  end

  ddr3_init_seq_refresh_ctr #(
    .T_REFI       (T_REFI),
    .REF_POSTPONE (REF_POSTPONE)
  ) u_refresh (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (ref_en_c),
    .ack_i   (ctl_ref_ack_i),
    .ref_o   (ctl_ref_o),
    .urg_o   (ctl_urg_o),
    .ovf_o   (ref_ovf_o)
  );

  assign dfi_rst_no = rst_n_q;
  assign dfi_cke_o  = cke_q;
  assign dfi_cs_no  = cs_n_q;
  assign dfi_odt_o  = 1'b0;
  assign ctl_req_o  = req_q;
  assign ctl_cmd_o  = cmd_q;
  assign ctl_ba_o   = ba_q;
  assign ctl_adr_o  = adr_q;
  assign ctl_run_o  = run_q;
  assign mrs_ack_o  = ack_q;

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Directed bench for ddr3_init_seq at 100 MHz with power-up waits divided by 100.
module tb_ddr3_init_seq;

  localparam logic [2:0] C_MRS  = 3'b000;
  localparam logic [2:0] C_PRE  = 3'b010;
  localparam logic [2:0] C_ZQCL = 3'b110;
  localparam logic [2:0] C_NOOP = 3'b111;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctl_rdy_i = 1'b1;
  logic        ctl_idle_i = 1'b1;
  logic        ctl_ref_ack_i = 1'b0;
  logic        mrs_req_i = 1'b0;
  logic [2:0]  mrs_ba_i = 3'd0;
  logic [12:0] mrs_adr_i = 13'h0;
  logic        dfi_rst_no, dfi_cke_o, dfi_cs_no, dfi_odt_o;
  logic        ctl_req_o, ctl_run_o, ctl_ref_o, ctl_urg_o, ref_ovf_o, mrs_ack_o;
  logic [2:0]  ctl_cmd_o, ctl_ba_o;
  logic [12:0] ctl_adr_o;

  int n_checks = 0;
  int n_fail   = 0;
  int rn       = 0;

  always #5 clock = ~clock;

  ddr3_init_seq #(
    .DDR_FREQ_MHZ(100), .DDR_ROW_BITS(13), .CL(6), .CWL(5), .WR(6),
    .RTT_NOM(0), .REF_POSTPONE(8), .TIME_DIV(100)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .dfi_rst_no(dfi_rst_no), .dfi_cke_o(dfi_cke_o), .dfi_cs_no(dfi_cs_no), .dfi_odt_o(dfi_odt_o),
    .ctl_req_o(ctl_req_o), .ctl_rdy_i(ctl_rdy_i), .ctl_cmd_o(ctl_cmd_o), .ctl_ba_o(ctl_ba_o),
    .ctl_adr_o(ctl_adr_o), .ctl_run_o(ctl_run_o), .ctl_idle_i(ctl_idle_i), .ctl_ref_o(ctl_ref_o),
    .ctl_urg_o(ctl_urg_o), .ctl_ref_ack_i(ctl_ref_ack_i), .ref_ovf_o(ref_ovf_o),
    .mrs_req_i(mrs_req_i), .mrs_ba_i(mrs_ba_i), .mrs_adr_i(mrs_adr_i), .mrs_ack_o(mrs_ack_o)
  );

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ctl_req_o) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({dfi_rst_no, dfi_cke_o, dfi_cs_no, dfi_odt_o, ctl_req_o, ctl_run_o, ctl_ref_o, ctl_urg_o,
         ref_ovf_o, mrs_ack_o} !== 10'b0010000000) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 0010000000", {dfi_rst_no, dfi_cke_o, dfi_cs_no,
               dfi_odt_o, ctl_req_o, ctl_run_o, ctl_ref_o, ctl_urg_o, ref_ovf_o, mrs_ack_o});
    end
    n_checks++;
    if ({ctl_cmd_o, ctl_ba_o, ctl_adr_o} !== {C_NOOP, 3'd0, 13'h0}) begin
      n_fail++;
      $display("FAIL reset_cmd got cmd=%b ba=%0d adr=%h exp 111/0/000", ctl_cmd_o, ctl_ba_o, ctl_adr_o);
    end
  endtask

  task automatic test_init_timing();
    int n;
    reset_n = 1'b1;
    n = 0;
    while (!dfi_rst_no && n < 1000) begin @(negedge clock); n++; end
    n_checks++;
    if (n != 200) begin n_fail++; $display("FAIL rst_no_delay got %0d exp 200", n); end
    n_checks++;
    if (dfi_cke_o !== 1'b0) begin n_fail++; $display("FAIL cke_early got %b exp 0", dfi_cke_o); end
    n = 0;
    while (!dfi_cke_o && n < 1000) begin @(negedge clock); n++; end
    n_checks++;
    if (n != 500) begin n_fail++; $display("FAIL cke_delay got %0d exp 500", n); end
    n_checks++;
    if (dfi_cs_no !== 1'b0) begin n_fail++; $display("FAIL cs_no got %b exp 0", dfi_cs_no); end
  endtask

  task automatic test_mr_sequence();
    bit ok;
    int n;
    wait_req(50, ok);
    n_checks++;
    if (!ok || {ctl_cmd_o, ctl_ba_o, ctl_adr_o} !== {C_MRS, 3'd2, 13'h000}) begin
      n_fail++;
      $display("FAIL mr2 got req=%b cmd=%b ba=%0d adr=%h exp MRS/2/000", ok, ctl_cmd_o, ctl_ba_o, ctl_adr_o);
    end
    @(negedge clock);
    wait_req(20, ok);
    n_checks++;
    if (!ok || {ctl_cmd_o, ctl_ba_o, ctl_adr_o} !== {C_MRS, 3'd3, 13'h000}) begin
      n_fail++;
      $display("FAIL mr3 got req=%b cmd=%b ba=%0d adr=%h exp MRS/3/000", ok, ctl_cmd_o, ctl_ba_o, ctl_adr_o);
    end
    @(negedge clock);
    ctl_rdy_i = 1'b0;
    wait_req(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mr1_req got 0 exp 1"); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({ctl_req_o, ctl_cmd_o, ctl_ba_o, ctl_adr_o} !== {1'b1, C_MRS, 3'd1, 13'h000}) begin
        n_fail++;
        $display("FAIL mr1_stall[%0d] got req=%b cmd=%b ba=%0d adr=%h exp 1/MRS/1/000", i,
                 ctl_req_o, ctl_cmd_o, ctl_ba_o, ctl_adr_o);
      end
      if (i < 9) @(negedge clock);
    end
    ctl_rdy_i = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({ctl_req_o, ctl_cmd_o} !== {1'b0, C_NOOP}) begin
      n_fail++;
      $display("FAIL mr1_release got req=%b cmd=%b exp 0/111", ctl_req_o, ctl_cmd_o);
    end
    wait_req(20, ok);
    n_checks++;
    if (!ok || {ctl_cmd_o, ctl_ba_o, ctl_adr_o} !== {C_MRS, 3'd0, 13'h520}) begin
      n_fail++;
      $display("FAIL mr0 got req=%b cmd=%b ba=%0d adr=%h exp MRS/0/520", ok, ctl_cmd_o, ctl_ba_o, ctl_adr_o);
    end
    @(negedge clock);
    wait_req(30, ok);
    n_checks++;
    if (!ok || {ctl_cmd_o, ctl_ba_o, ctl_adr_o} !== {C_ZQCL, 3'd0, 13'h400}) begin
      n_fail++;
      $display("FAIL zqcl got req=%b cmd=%b ba=%0d adr=%h exp ZQCL/0/400", ok, ctl_cmd_o, ctl_ba_o, ctl_adr_o);
    end
    n = 0;
    while (!ctl_run_o && n < 1100) begin @(negedge clock); n++; end
    n_checks++;
    if (!ctl_run_o || n < 1024) begin
      n_fail++;
      $display("FAIL run_rise got run=%b after %0d cycles exp 1 after >=1024", ctl_run_o, n);
    end
    rn = 0;
  endtask

  task automatic test_ack_zero();
    @(negedge clock); rn++;
    ctl_ref_ack_i = 1'b1;
    @(negedge clock); rn++;
    ctl_ref_ack_i = 1'b0;
    @(negedge clock); rn++;
    n_checks++;
    if ({ctl_ref_o, ref_ovf_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL ack_zero got ref=%b ovf=%b exp 0/0", ctl_ref_o, ref_ovf_o);
    end
  endtask

  task automatic test_refresh();
    while (!ctl_ref_o && rn < 1000) begin @(negedge clock); rn++; end
    n_checks++;
    if (rn != 780) begin n_fail++; $display("FAIL ref_first got %0d exp 780", rn); end
    while (!ctl_urg_o && rn < 7000) begin @(negedge clock); rn++; end
    n_checks++;
    if (rn != 6240 || ref_ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL urg_rise got cyc=%0d ovf=%b exp 6240/0", rn, ref_ovf_o);
    end
    while (!ref_ovf_o && rn < 7500) begin @(negedge clock); rn++; end
    n_checks++;
    if (rn != 7020 || ctl_urg_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_rise got cyc=%0d urg=%b exp 7020/1", rn, ctl_urg_o);
    end
    @(negedge clock); rn++;
    ctl_ref_ack_i = 1'b1;
    @(negedge clock); rn++;
    ctl_ref_ack_i = 1'b0;
    n_checks++;
    if ({ctl_ref_o, ctl_urg_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL debt7 got ref=%b urg=%b exp 1/0", ctl_ref_o, ctl_urg_o);
    end
    while (rn < 7799) begin @(negedge clock); rn++; end
    ctl_ref_ack_i = 1'b1;
    @(negedge clock); rn++;
    ctl_ref_ack_i = 1'b0;
    n_checks++;
    if ({ctl_ref_o, ctl_urg_o, ref_ovf_o} !== 3'b101) begin
      n_fail++;
      $display("FAIL tick_ack got ref=%b urg=%b ovf=%b exp 1/0/1", ctl_ref_o, ctl_urg_o, ref_ovf_o);
    end
    for (int i = 0; i < 7; i++) begin
      ctl_ref_ack_i = 1'b1;
      @(negedge clock); rn++;
      ctl_ref_ack_i = 1'b0;
      if (i == 5) begin
        n_checks++;
        if (ctl_ref_o !== 1'b1) begin n_fail++; $display("FAIL drain6 got ref=%b exp 1", ctl_ref_o); end
      end
    end
    n_checks++;
    if (ctl_ref_o !== 1'b0) begin n_fail++; $display("FAIL drain7 got ref=%b exp 0", ctl_ref_o); end
  endtask

  task automatic test_mrs();
    bit ok;
    int n;
    logic [12:0] a;
    ctl_idle_i = 1'b0;
    mrs_ba_i   = 3'd1;
    mrs_adr_i  = 13'h044;
    mrs_req_i  = 1'b1;
    @(negedge clock);
    n_checks++;
    if (ctl_run_o !== 1'b0) begin n_fail++; $display("FAIL mrs_run_drop got %b exp 0", ctl_run_o); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ctl_req_o !== 1'b0) begin n_fail++; $display("FAIL mrs_idle_hold[%0d] got req=%b exp 0", i, ctl_req_o); end
      @(negedge clock);
    end
    ctl_idle_i = 1'b1;
    wait_req(10, ok);
    a = ctl_adr_o;
    n_checks++;
    if (!ok || ctl_cmd_o !== C_PRE || a[10] !== 1'b1) begin
      n_fail++;
      $display("FAIL mrs_pre got req=%b cmd=%b adr=%h exp 1/PRE/a10=1", ok, ctl_cmd_o, a);
    end
    @(negedge clock);
    wait_req(10, ok);
    n_checks++;
    if (!ok || {ctl_cmd_o, ctl_ba_o, ctl_adr_o} !== {C_MRS, 3'd1, 13'h044}) begin
      n_fail++;
      $display("FAIL mrs_cmd got req=%b cmd=%b ba=%0d adr=%h exp MRS/1/044", ok, ctl_cmd_o, ctl_ba_o, ctl_adr_o);
    end
    n = 0;
    while (!mrs_ack_o && n < 40) begin @(negedge clock); n++; end
    n_checks++;
    if ({mrs_ack_o, ctl_run_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL mrs_ack got ack=%b run=%b exp 1/1", mrs_ack_o, ctl_run_o);
    end
    mrs_req_i = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({mrs_ack_o, ctl_run_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL mrs_ack_pulse got ack=%b run=%b exp 0/1", mrs_ack_o, ctl_run_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    while (!dfi_cke_o && n < 1000) begin @(negedge clock); n++; end
    wait_req(50, ok);
    @(negedge clock);
    wait_req(20, ok);
    n_checks++;
    if (!ok || ctl_ba_o !== 3'd3) begin n_fail++; $display("FAIL mid_mr3 got req=%b ba=%0d exp 1/3", ok, ctl_ba_o); end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({dfi_rst_no, dfi_cke_o, dfi_cs_no, dfi_odt_o, ctl_req_o, ctl_run_o, ctl_ref_o, ctl_urg_o,
         ref_ovf_o, mrs_ack_o, ctl_cmd_o} !== 13'b0010000000111) begin
      n_fail++;
      $display("FAIL mid_reset got %b exp 0010000000111", {dfi_rst_no, dfi_cke_o, dfi_cs_no,
               dfi_odt_o, ctl_req_o, ctl_run_o, ctl_ref_o, ctl_urg_o, ref_ovf_o, mrs_ack_o, ctl_cmd_o});
    end
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    while (!dfi_rst_no && n < 1000) begin @(negedge clock); n++; end
    n_checks++;
    if (n != 200) begin n_fail++; $display("FAIL mid_rst_no_delay got %0d exp 200", n); end
  endtask

  initial begin
    test_reset();
    test_init_timing();
    test_mr_sequence();
    test_ack_zero();
    test_refresh();
    test_mrs();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
